// File: rtl/histogramming.sv
// 16-bin streaming histogram: the upper nibble of each valid sample selects a saturating bin counter.
// Read-back on uo_out is registered and shows a bin count, the mode bin with status flags, or the total.
module histogramming (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBINS = 16;
  localparam int CNT_W = 8;
  localparam int TOT_W = 16;

  logic [CNT_W-1:0] bins_r [NBINS];
  logic [TOT_W-1:0] total_r;
  logic [7:0]       uo_r;

  logic             sample_valid_s;
  logic [3:0]       rd_bin_s;
  logic             clear_s;
  logic [1:0]       view_sel_s;
  logic [3:0]       bin_idx_s;
  logic             unused_s;

  logic [3:0]       mode_idx_s;
  logic [CNT_W-1:0] mode_cnt_s;
  logic             any_sat_s;
  logic [7:0]       rd_data_s;

  assign sample_valid_s = uio_in[0];
  assign rd_bin_s       = uio_in[4:1];
  assign clear_s        = uio_in[5];
  assign view_sel_s     = uio_in[7:6];
  assign bin_idx_s      = ui_in[7:4];
  assign unused_s       = ^ui_in[3:0];

  // Mode search over current bins: strict greater-than keeps the lowest index on ties
  always_comb begin
    mode_idx_s = 4'd0;
    mode_cnt_s = bins_r[0];
    any_sat_s  = 1'b0;
    for (int i = 0; i < NBINS; i++) begin
      if (bins_r[i] > mode_cnt_s) begin
        mode_cnt_s = bins_r[i];
        mode_idx_s = 4'(i);
      end else begin
        mode_cnt_s = mode_cnt_s;
        mode_idx_s = mode_idx_s;
      end
      any_sat_s = any_sat_s | (bins_r[i] == 8'hFF);
    end
  end

  // Read-back mux selected by view_sel
  always_comb begin
    rd_data_s = 8'h00;
    case (view_sel_s)
      2'b00:   rd_data_s = bins_r[rd_bin_s];
      2'b01:   rd_data_s = {1'b0, (total_r == 16'hFFFF), (total_r == 16'h0000), any_sat_s, mode_idx_s};
      2'b10:   rd_data_s = total_r[7:0];
      2'b11:   rd_data_s = total_r[15:8];
      default: rd_data_s = 8'h00;
    endcase
  end

  // Bin/total update and registered read-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBINS; i++) begin
        bins_r[i] <= 8'h00;
      end
      total_r <= 16'h0000;
      uo_r    <= 8'h00;
    end else begin
      uo_r <= rd_data_s;
      if (ena) begin
        if (clear_s) begin
          for (int i = 0; i < NBINS; i++) begin
            bins_r[i] <= 8'h00;
          end
          total_r <= 16'h0000;
        end else if (sample_valid_s) begin
          if (bins_r[bin_idx_s] != 8'hFF) begin
            bins_r[bin_idx_s] <= bins_r[bin_idx_s] + 8'd1;
          end
          if (total_r != 16'hFFFF) begin
            total_r <= total_r + 16'd1;
          end
        end
      end
    end
  end

  assign uo_out  = uo_r;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_histogramming.sv
// Self-checking bench for histogramming: directed scenarios plus randomized traffic,
// compared against an array-based reference histogram.
module tb_histogramming;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int nvec;
  int nfail;
  int mbin [16];
  int mtot;

  histogramming dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mbin[i] = 0;
    mtot = 0;
  endfunction

  function automatic logic [7:0] expect_view(input logic [1:0] v, input logic [3:0] rd);
    int best;
    int besti;
    int sat;
    best = -1; besti = 0; sat = 0;
    for (int i = 0; i < 16; i++) begin
      if (mbin[i] > best) begin best = mbin[i]; besti = i; end
      if (mbin[i] == 255) sat = 1;
    end
    case (v)
      2'd0: return 8'(mbin[rd]);
      2'd1: return 8'(besti + sat * 16 + (mtot == 0 ? 32 : 0) + (mtot == 65535 ? 64 : 0));
      2'd2: return 8'(mtot % 256);
      default: return 8'(mtot / 256);
    endcase
  endfunction

  // One clock of stimulus; the model follows the documented update rules.
  task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic e);
    @(negedge clk);
    ena    = e;
    ui_in  = d;
    uio_in = {2'b00, c, 4'h0, v};
    @(posedge clk);
    if (e) begin
      if (c) model_clear();
      else if (v) begin
        if (mbin[d[7:4]] < 255) mbin[d[7:4]]++;
        if (mtot < 65535) mtot++;
      end
    end
  endtask

  // Select a view, let two edges pass so uo_out reflects settled state, then compare.
  task automatic check_view(input logic [1:0] v, input logic [3:0] rd, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    ena    = 1'b1;
    uio_in = {v, 1'b0, rd, 1'b0};
    @(posedge clk);
    @(posedge clk);
    #1;
    exp = expect_view(v, rd);
    nvec++;
    assert (uo_out === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, uo_out, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    uio_in = 8'h01;
    ui_in  = 8'h70;
    @(posedge clk);
    #1;
    model_clear();
    nvec++;
    assert (uo_out === 8'h00) else begin
      nfail++;
      $error("FAIL reset_uo: observed %h expected %h", uo_out, 8'h00);
    end
    @(negedge clk);
    rst    = 1'b0;
    uio_in = 8'h00;
  endtask

  initial begin
    nvec = 0; nfail = 0;
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    nvec++;
    assert (uio_out === 8'h00 && uio_oe === 8'h00) else begin
      nfail++;
      $error("FAIL uio_const: observed %h/%h expected 00/00", uio_out, uio_oe);
    end
    check_view(2'b01, 4'd0, "reset_view01");
    nvec++;
    assert (expect_view(2'b01, 4'd0) === 8'h20) else begin
      nfail++;
      $error("FAIL model_reset01: observed %h expected %h", expect_view(2'b01, 4'd0), 8'h20);
    end

    // basic counts
    repeat (3) drive(1'b1, 8'h50, 1'b0, 1'b1);
    drive(1'b1, 8'hA3, 1'b0, 1'b1);
    check_view(2'b00, 4'd5, "bin5");
    check_view(2'b00, 4'd10, "bin10");
    check_view(2'b01, 4'd0, "mode_basic");
    check_view(2'b10, 4'd0, "total_lo_basic");

    // saturation of a bin, total crossing a byte
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (300) drive(1'b1, 8'h10, 1'b0, 1'b1);
    check_view(2'b00, 4'd1, "bin1_sat");
    check_view(2'b01, 4'd0, "mode_sat");
    check_view(2'b10, 4'd0, "total_lo_300");
    check_view(2'b11, 4'd0, "total_hi_300");

    // tie breaks toward the lower index
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 8'h70, 1'b0, 1'b1);
    repeat (2) drive(1'b1, 8'h30, 1'b0, 1'b1);
    check_view(2'b01, 4'd0, "mode_tie");

    // clear beats a simultaneous sample
    drive(1'b1, 8'h30, 1'b1, 1'b1);
    check_view(2'b00, 4'd3, "clear_bin3");
    check_view(2'b10, 4'd0, "clear_total");
    drive(1'b1, 8'hF0, 1'b0, 1'b1);
    check_view(2'b00, 4'd15, "bin15_after_clear");

    // ena low freezes counts
    repeat (5) drive(1'b1, 8'hF0, 1'b0, 1'b0);
    check_view(2'b00, 4'd15, "ena_freeze_bin15");
    check_view(2'b10, 4'd0, "ena_freeze_total");

    // back-to-back samples to alternating bins
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2 == 0) ? 8'h2B : 8'hE1, 1'b0, 1'b1);
    check_view(2'b00, 4'd2, "b2b_bin2");
    check_view(2'b01, 4'd0, "b2b_mode");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 9) != 0));
      if (n % 25 == 24)
        check_view(2'($urandom), 4'($urandom), "random");
    end

    // reset after data
    do_reset();
    check_view(2'b01, 4'd0, "post_rst_view01");
    check_view(2'b10, 4'd0, "post_rst_total_lo");
    check_view(2'b11, 4'd0, "post_rst_total_hi");
    check_view(2'b00, 4'd1, "post_rst_bin1");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
